// File: rtl/ipid_slice_tx_if.sv
// Signature load port for the IP-ID slice transmitter.
// The producer drives valid/data and watches ready; the transmitter drives ready.
interface ipid_slice_tx_if #(
    parameter int SIG_W = 256
);
    logic             sig_load_valid;
    logic             sig_load_ready;
    logic [SIG_W-1:0] sig_load_data;

    modport master (
        output sig_load_valid,
        output sig_load_data,
        input  sig_load_ready
    );

    modport slave (
        input  sig_load_valid,
        input  sig_load_data,
        output sig_load_ready
    );
endinterface

// File: rtl/ipid_slice_tx.sv
// Transmit end of the GPIO IP-ID ingest link. Signatures are taken into a
// one-entry holding buffer, moved into a shift register and streamed MSB
// first as SLICE_W-bit slices on gpio_out[SLICE_W+7:8], one per clock.
// gpio_out[0] = strobe, [1] = first slice, [2] = last slice.
// The output registers always hold the value for the cycle being displayed,
// so the state that decides a slice also loads it into the output register.
module ipid_slice_tx #(
    parameter int N       = 24,
    parameter int SIG_W   = 256,
    parameter int SLICE_W = 16,
    parameter int NUM_SIG = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    ipid_slice_tx_if.slave       load,
    output logic [N-1:0]         gpio_out,
    output logic [N-1:0]         gpio_en,
    output logic                 busy,
    output logic                 done,
    output logic [3:0]           sig_cnt
);

    localparam int SLICES = SIG_W / SLICE_W;
    localparam int IDX_W  = $clog2(SLICES);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SLICES - 1);
    localparam logic [3:0]       NUM_SIG_C = 4'(NUM_SIG);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;

    logic                 start_q_r;
    logic                 start_edge_s;

    logic [SIG_W-1:0]     buf_r;
    logic                 buf_full_r;
    logic                 accept_s;
    logic                 take_s;

    logic [SIG_W-1:0]     shift_r;
    logic [SIG_W-1:0]     shift_nxt_s;
    logic [IDX_W-1:0]     slice_idx_r;
    logic [IDX_W-1:0]     slice_idx_nxt_s;
    logic [IDX_W-1:0]     slice_idx_inc_s;
    logic                 slice_last_s;

    logic [3:0]           sig_cnt_r;
    logic [3:0]           sig_cnt_nxt_s;
    logic [3:0]           sig_cnt_inc_s;
    logic                 sess_end_s;

    logic [SLICE_W-1:0]   slice_r;
    logic [SLICE_W-1:0]   slice_nxt_s;
    logic                 strobe_r;
    logic                 strobe_nxt_s;
    logic                 first_r;
    logic                 first_nxt_s;
    logic                 last_r;
    logic                 last_nxt_s;
    logic                 busy_r;
    logic                 busy_nxt_s;
    logic                 done_r;
    logic                 done_nxt_s;

    // Start is edge-triggered; a held level never re-arms a session.
    assign start_edge_s    = start & ~start_q_r;
    assign accept_s        = load.sig_load_valid & ~buf_full_r;
    assign slice_last_s    = (slice_idx_r == LAST_IDX);
    assign slice_idx_inc_s = slice_idx_r + IDX_W'(1);
    // Saturating count of fully sent signatures.
    assign sig_cnt_inc_s   = (sig_cnt_r == NUM_SIG_C) ? sig_cnt_r : (sig_cnt_r + 4'd1);
    assign sess_end_s      = (sig_cnt_inc_s == NUM_SIG_C);

    assign load.sig_load_ready = ~buf_full_r;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_edge_s) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (buf_full_r) begin
                    state_nxt_s = ST_SEND;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_SEND: begin
                if (!slice_last_s) begin
                    state_nxt_s = ST_SEND;
                end else if (sess_end_s) begin
                    state_nxt_s = ST_DONE;
                end else if (buf_full_r) begin
                    state_nxt_s = ST_SEND;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM output decode: next values for the output and datapath registers.
    always_comb begin
        shift_nxt_s     = shift_r;
        slice_idx_nxt_s = slice_idx_r;
        sig_cnt_nxt_s   = sig_cnt_r;
        slice_nxt_s     = slice_r;
        strobe_nxt_s    = 1'b0;
        first_nxt_s     = 1'b0;
        last_nxt_s      = 1'b0;
        busy_nxt_s      = busy_r;
        done_nxt_s      = 1'b0;
        take_s          = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_edge_s) begin
                    busy_nxt_s    = 1'b1;
                    sig_cnt_nxt_s = 4'd0;
                end else begin
                    busy_nxt_s    = 1'b0;
                end
            end
            ST_WAIT: begin
                busy_nxt_s = 1'b1;
                if (buf_full_r) begin
                    // Slice 0 goes straight to the output register.
                    take_s          = 1'b1;
                    slice_nxt_s     = buf_r[SIG_W-1 -: SLICE_W];
                    shift_nxt_s     = buf_r << SLICE_W;
                    slice_idx_nxt_s = '0;
                    strobe_nxt_s    = 1'b1;
                    first_nxt_s     = 1'b1;
                    last_nxt_s      = (LAST_IDX == '0);
                end else begin
                    // Underrun: strobe low, slice data holds.
                    slice_nxt_s = slice_r;
                end
            end
            ST_SEND: begin
                busy_nxt_s = 1'b1;
                if (!slice_last_s) begin
                    slice_nxt_s     = shift_r[SIG_W-1 -: SLICE_W];
                    shift_nxt_s     = shift_r << SLICE_W;
                    slice_idx_nxt_s = slice_idx_inc_s;
                    strobe_nxt_s    = 1'b1;
                    last_nxt_s      = (slice_idx_inc_s == LAST_IDX);
                end else begin
                    sig_cnt_nxt_s = sig_cnt_inc_s;
                    if (sess_end_s) begin
                        done_nxt_s  = 1'b1;
                        slice_nxt_s = '0;
                    end else if (buf_full_r) begin
                        // Back-to-back signature: slice 0 follows with no gap.
                        take_s          = 1'b1;
                        slice_nxt_s     = buf_r[SIG_W-1 -: SLICE_W];
                        shift_nxt_s     = buf_r << SLICE_W;
                        slice_idx_nxt_s = '0;
                        strobe_nxt_s    = 1'b1;
                        first_nxt_s     = 1'b1;
                        last_nxt_s      = (LAST_IDX == '0);
                    end else begin
                        slice_nxt_s = slice_r;
                    end
                end
            end
            ST_DONE: begin
                busy_nxt_s  = 1'b0;
                slice_nxt_s = '0;
            end
            default: begin
                busy_nxt_s  = 1'b0;
                slice_nxt_s = '0;
            end
        endcase
    end

    // Start edge detector and holding buffer with its full flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_q_r  <= 1'b0;
            buf_r      <= '0;
            buf_full_r <= 1'b0;
        end else begin
            start_q_r <= start;
            if (accept_s) begin
                buf_r      <= load.sig_load_data;
                buf_full_r <= 1'b1;
            end else if (take_s) begin
                buf_full_r <= 1'b0;
            end else begin
                buf_full_r <= buf_full_r;
            end
        end
    end

    // Shift register, slice index, signature count and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_r     <= '0;
            slice_idx_r <= '0;
            sig_cnt_r   <= 4'd0;
            slice_r     <= '0;
            strobe_r    <= 1'b0;
            first_r     <= 1'b0;
            last_r      <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            shift_r     <= shift_nxt_s;
            slice_idx_r <= slice_idx_nxt_s;
            sig_cnt_r   <= sig_cnt_nxt_s;
            slice_r     <= slice_nxt_s;
            strobe_r    <= strobe_nxt_s;
            first_r     <= first_nxt_s;
            last_r      <= last_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
        end
    end

    // GPIO word assembly from the output registers.
    always_comb begin
        gpio_out                = '0;
        gpio_out[SLICE_W+7:8]   = slice_r;
        gpio_out[2:0]           = {last_r, first_r, strobe_r};
    end

    assign gpio_en = {N{busy_r}};
    assign busy    = busy_r;
    assign done    = done_r;
    assign sig_cnt = sig_cnt_r;

endmodule

// File: tb/tb_ipid_slice_tx.sv
// Bench for ipid_slice_tx: a scoreboard queue of expected slices is filled
// as signatures are accepted and drained by a negedge monitor; sessions are
// driven from tables of signatures with per-entry load gaps.
`timescale 1ns/1ps
module tb_ipid_slice_tx;

    localparam int N       = 24;
    localparam int SIG_W   = 256;
    localparam int SLICE_W = 16;
    localparam int NUM_SIG = 10;
    localparam int SLICES  = 16;
    localparam int NOLIM   = 100000;

    localparam logic [255:0] SIG_A =
        256'haa12953e_0b7c41d9_6f2e88a3_1c5d7e90_4b3a2f61_d8e7c6b5_a49382f7_16085ecd;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] gpio_out;
    logic [N-1:0] gpio_en;
    logic         busy;
    logic         done;
    logic [3:0]   sig_cnt;

    ipid_slice_tx_if #(.SIG_W(SIG_W)) load_if ();

    ipid_slice_tx #(
        .N(N), .SIG_W(SIG_W), .SLICE_W(SLICE_W), .NUM_SIG(NUM_SIG)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .load(load_if),
        .gpio_out(gpio_out), .gpio_en(gpio_en),
        .busy(busy), .done(done), .sig_cnt(sig_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic        first;
        logic        last;
        int          idle_min;
        int          idle_max;
    } slice_t;

    typedef struct {
        logic [255:0] sig;
        int           gap;       // clocks after previous last slice before loading
        int           idle_min;  // expected strobe-low cycles before slice 0
        int           idle_max;
    } vec_t;

    slice_t sb_q[$];
    vec_t   tab[10];

    int vec_cnt  = 0;
    int err_cnt  = 0;
    int idle_run = 0;
    int done_cnt = 0;
    int strobe_cnt = 0;
    int last_cnt = 0;
    logic [15:0] prev_data = 16'h0000;
    logic        prev_last = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        vec_cnt++;
        if (act < lo || act > hi) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic logic [255:0] mk_sig(input int seed);
        logic [255:0] v;
        logic [31:0]  x;
        v = '0;
        x = 32'h2545f491 ^ 32'(seed);
        for (int w = 0; w < 8; w++) begin
            x = x * 32'd1664525 + 32'd1013904223;
            v[w*32 +: 32] = x;
        end
        return v;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Wait for ready, offer the signature, and queue its 16 expected slices.
    task automatic load_sig(input logic [255:0] sig, input int idle_min, input int idle_max,
                            input bit garbage);
        bit ok;
        slice_t e;
        ok = 1'b0;
        for (int c = 0; c < 2000 && !ok; c++) begin
            @(negedge clk);
            if (load_if.sig_load_ready) begin
                load_if.sig_load_valid = 1'b1;
                load_if.sig_load_data  = sig;
                ok = 1'b1;
            end else if (garbage) begin
                load_if.sig_load_valid = 1'b1;
                load_if.sig_load_data  = ~sig;
            end else begin
                load_if.sig_load_valid = 1'b0;
            end
        end
        chk("load_ready_seen", 256'(ok), 256'd1);
        if (ok) begin
            for (int s = 0; s < SLICES; s++) begin
                e.data     = sig[SIG_W-1-s*SLICE_W -: SLICE_W];
                e.first    = (s == 0);
                e.last     = (s == SLICES - 1);
                e.idle_min = (s == 0) ? idle_min : 0;
                e.idle_max = (s == 0) ? idle_max : 0;
                sb_q.push_back(e);
            end
            @(negedge clk);
        end
        load_if.sig_load_valid = 1'b0;
    endtask

    // Output monitor: drains the scoreboard and checks framing, hold and done.
    always @(negedge clk) begin
        slice_t e;
        if (!rst) begin
            sb_q.delete();
            idle_run  = 0;
            prev_data = 16'h0000;
            prev_last = 1'b0;
        end else begin
            chk("framing_zero", 256'(gpio_out[7:3]), 256'd0);
            if (gpio_out[0]) begin
                strobe_cnt++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_slice", 256'(gpio_out[23:8]), 256'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("slice_data", 256'(gpio_out[23:8]), 256'(e.data));
                    chk("slice_first", 256'(gpio_out[1]), 256'(e.first));
                    chk("slice_last", 256'(gpio_out[2]), 256'(e.last));
                    chk_rng("idle_before_slice", idle_run, e.idle_min, e.idle_max);
                end
                if (gpio_out[2]) last_cnt++;
                idle_run = 0;
            end else begin
                chk("idle_first_last", 256'(gpio_out[2:1]), 256'd0);
                if (done) chk("done_slice_zero", 256'(gpio_out[23:8]), 256'd0);
                else      chk("underrun_hold", 256'(gpio_out[23:8]), 256'(prev_data));
                if (busy) idle_run++;
                else      idle_run = 0;
            end
            if (done) begin
                done_cnt++;
                chk("done_after_last", 256'(prev_last), 256'd1);
                chk("done_sig_cnt", 256'(sig_cnt), 256'(NUM_SIG));
                chk("done_queue_empty", 256'(sb_q.size()), 256'd0);
            end
            prev_last = gpio_out[0] & gpio_out[2];
            prev_data = gpio_out[23:8];
        end
    end

    initial begin
        int s0, d0, l0;
        load_if.sig_load_valid = 1'b0;
        load_if.sig_load_data  = '0;

        // Reset state.
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_gpio_out", 256'(gpio_out), 256'd0);
        chk("rst_gpio_en", 256'(gpio_en), 256'd0);
        chk("rst_busy", 256'(busy), 256'd0);
        chk("rst_done", 256'(done), 256'd0);
        chk("rst_sig_cnt", 256'(sig_cnt), 256'd0);
        #2 rst = 1'b1;
        tick();
        chk("post_rst_ready", 256'(load_if.sig_load_ready), 256'd1);

        // Preloaded single signature: 16 slices, first slice 2 clk after the start edge.
        s0 = strobe_cnt;
        load_sig(SIG_A, 1, 1, 1'b0);
        chk("preload_ready_low", 256'(load_if.sig_load_ready), 256'd0);
        start = 1'b1;
        @(negedge clk);
        chk("start_busy", 256'(busy), 256'd1);
        chk("start_gpio_en", 256'(gpio_en), 256'({N{1'b1}}));
        start = 1'b0;
        for (int c = 0; c < 100 && strobe_cnt < s0 + 16; c++) tick();
        chk("sig_a_strobes", 256'(strobe_cnt - s0), 256'd16);

        // Underrun, then reset while slice 7 of the next signature is on the pins.
        load_sig(mk_sig(77), 0, NOLIM, 1'b0);
        for (int c = 0; c < 200 && strobe_cnt < s0 + 24; c++) tick();
        chk("reached_slice7", 256'(strobe_cnt - s0), 256'd24);
        #1 rst = 1'b0;
        #1;
        chk("midrst_gpio_out", 256'(gpio_out), 256'd0);
        chk("midrst_gpio_en", 256'(gpio_en), 256'd0);
        chk("midrst_busy", 256'(busy), 256'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("rel_ready", 256'(load_if.sig_load_ready), 256'd1);
        chk("rel_sig_cnt", 256'(sig_cnt), 256'd0);

        // Run 1: ten signatures, no gaps, start held high through DONE,
        // garbage offered while the buffer is full.
        for (int i = 0; i < 10; i++) begin
            tab[i].sig      = mk_sig(i);
            tab[i].gap      = 0;
            tab[i].idle_min = (i == 0) ? 1 : 0;
            tab[i].idle_max = (i == 0) ? 1 : 0;
        end
        s0 = strobe_cnt; d0 = done_cnt;
        load_sig(tab[0].sig, tab[0].idle_min, tab[0].idle_max, 1'b0);
        start = 1'b1;
        for (int i = 1; i < 10; i++) load_sig(tab[i].sig, tab[i].idle_min, tab[i].idle_max, 1'b1);
        for (int c = 0; c < 400 && done_cnt == d0; c++) tick();
        chk("run1_strobes", 256'(strobe_cnt - s0), 256'd160);
        chk("run1_sig_cnt", 256'(sig_cnt), 256'd10);
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("run1_idle_busy", 256'(busy), 256'd0);
        end
        chk("run1_done_once", 256'(done_cnt - d0), 256'd1);
        chk("run1_sig_cnt_hold", 256'(sig_cnt), 256'd10);
        start = 1'b0;
        tick();

        // Run 2: underrun gaps, extra start pulses while busy.
        for (int i = 0; i < 10; i++) begin
            tab[i].sig = mk_sig(100 + i);
            tab[i].gap = (i == 1) ? 5 : ((i == 4) ? 2 : 0);
            tab[i].idle_min = (i == 0) ? 1 : tab[i].gap;
            tab[i].idle_max = (i == 0) ? 1 : ((tab[i].gap > 0) ? NOLIM : 0);
        end
        s0 = strobe_cnt; d0 = done_cnt; l0 = last_cnt;
        load_sig(tab[0].sig, tab[0].idle_min, tab[0].idle_max, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        fork
            begin
                for (int i = 1; i < 10; i++) begin
                    if (tab[i].gap > 0) begin
                        for (int c = 0; c < 400 && last_cnt < l0 + i; c++) tick();
                        repeat (tab[i].gap) @(negedge clk);
                    end
                    load_sig(tab[i].sig, tab[i].idle_min, tab[i].idle_max, 1'b0);
                end
            end
            begin
                for (int k = 0; k < 4; k++) begin
                    repeat (20) @(negedge clk);
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                end
            end
        join
        for (int c = 0; c < 400 && done_cnt == d0; c++) tick();
        chk("run2_strobes", 256'(strobe_cnt - s0), 256'd160);
        chk("run2_sig_cnt", 256'(sig_cnt), 256'd10);
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("run2_idle_busy", 256'(busy), 256'd0);
        end
        chk("run2_done_once", 256'(done_cnt - d0), 256'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
